// File: rtl/mdu.sv
// Multiply/divide unit for the E stage: owns HI/LO and models multi-cycle latency with busy.
// Results are computed at start, held in pend_hi/pend_lo, and committed when the counter expires.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [3:0]  mdOp,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic [31:0] mdOut
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = ($clog2(MAX_CYCLES + 1) < 4) ? 4 : $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [31:0]   hi, lo;
    logic [31:0]   pend_hi, pend_lo;
    logic          pend_valid;

    logic          start, done, is_div;
    logic [63:0]   prod_s, prod_u;
    logic [31:0]   a_mag, b_mag, b_mag_safe, b_safe;
    logic [31:0]   q_mag, r_mag, q_s, r_s, q_u, r_u;
    logic [31:0]   res_hi, res_lo;

    assign busy = (state == RUN);

    // Two's-complement products on sign/zero-extended 64-bit operands.
    assign prod_s = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
    assign prod_u = {32'd0, srcA} * {32'd0, srcB};

    // Signed division via magnitudes: no signed overflow on 0x80000000 / -1,
    // and the divisor is forced non-zero so the datapath never divides by zero.
    assign a_mag      = srcA[31] ? (32'd0 - srcA) : srcA;
    assign b_mag      = srcB[31] ? (32'd0 - srcB) : srcB;
    assign b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign b_safe     = (srcB == 32'd0) ? 32'd1 : srcB;
    assign q_mag      = a_mag / b_mag_safe;
    assign r_mag      = a_mag % b_mag_safe;
    assign q_s        = (srcA[31] ^ srcB[31]) ? (32'd0 - q_mag) : q_mag;
    assign r_s        = srcA[31] ? (32'd0 - r_mag) : r_mag;
    assign q_u        = srcA / b_safe;
    assign r_u        = srcA % b_safe;

    always_comb begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
        is_div = 1'b0;
        case (mdOp)
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV: begin
                res_hi = r_s;
                res_lo = q_s;
                is_div = 1'b1;
            end
            OP_DIVU: begin
                res_hi = r_u;
                res_lo = q_u;
                is_div = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        start      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (en && (mdOp >= OP_MULT) && (mdOp <= OP_DIVU)) begin
                    start      = 1'b1;
                    state_next = RUN;
                    cnt_next   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                end
            end
            RUN: begin
                if (cnt == CW'(1)) begin
                    done       = 1'b1;
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            hi         <= '0;
            lo         <= '0;
            pend_hi    <= '0;
            pend_lo    <= '0;
            pend_valid <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (start) begin
                pend_hi    <= res_hi;
                pend_lo    <= res_lo;
                pend_valid <= !(is_div && (srcB == 32'd0));
            end
            if (done && pend_valid) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
            if (state == IDLE && en && mdOp == OP_MTHI) hi <= srcA;
            if (state == IDLE && en && mdOp == OP_MTLO) lo <= srcA;
        end
    end

    always_comb begin
        mdOut = 32'd0;
        if (en && mdOp == OP_MFHI) mdOut = hi;
        if (en && mdOp == OP_MFLO) mdOut = lo;
    end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: driver pushes expected mfhi/mflo data into exp_q,
// a negedge monitor pops and compares whenever a read is on the bus.
module tb_mdu;

    logic        clk;
    logic        reset;
    logic        en;
    logic [3:0]  mdOp;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic [31:0] mdOut;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .mdOp  (mdOp),
        .srcA  (srcA),
        .srcB  (srcB),
        .busy  (busy),
        .mdOut (mdOut)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!reset && en && (mdOp == 4'd5 || mdOp == 4'd6)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_read: got 0x%08h expected none", mdOut);
            end else begin
                chk(name_q.pop_front(), mdOut, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en   = 1'b0;
        mdOp = 4'd0;
        srcA = 32'd0;
        srcB = 32'd0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        en   = 1'b1;
        mdOp = op;
        srcA = a;
        srcB = b;
        step();
        idle_inputs();
    endtask

    task automatic read(input logic [3:0] op, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        en   = 1'b1;
        mdOp = op;
        step();
        idle_inputs();
    endtask

    // Counts cycles with busy high, starting at the current sample; bounded.
    task automatic count_busy(output int c);
        c = 0;
        while (busy && c < 100) begin
            c++;
            step();
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int cycles, input string name);
        int c;
        issue(op, a, b);
        count_busy(c);
        chk({name, "_busy_cycles"}, 32'(c), 32'(cycles));
    endtask

    initial begin
        int c;
        idle_inputs();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        step();

        chk("reset_busy", {31'd0, busy}, 32'd0);
        read(4'd5, 32'd0, "reset_hi");
        read(4'd6, 32'd0, "reset_lo");

        run_op(4'd1, 32'hFFFFFFFF, 32'd2, 5, "mult");
        read(4'd5, 32'hFFFFFFFF, "mult_hi");
        read(4'd6, 32'hFFFFFFFE, "mult_lo");

        run_op(4'd2, 32'hFFFFFFFF, 32'd2, 5, "multu");
        read(4'd5, 32'h00000001, "multu_hi");
        read(4'd6, 32'hFFFFFFFE, "multu_lo");

        run_op(4'd3, 32'hFFFFFFF9, 32'd2, 10, "div");
        read(4'd6, 32'hFFFFFFFD, "div_lo");
        read(4'd5, 32'hFFFFFFFF, "div_hi");

        run_op(4'd4, 32'd7, 32'd2, 10, "divu");
        read(4'd6, 32'd3, "divu_lo");
        read(4'd5, 32'd1, "divu_hi");

        issue(4'd7, 32'h12345678, 32'd0);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        issue(4'd8, 32'h00000000, 32'd0);
        read(4'd5, 32'h12345678, "mthi_hi");
        read(4'd6, 32'h00000000, "mtlo_lo");

        // reads with en low return zero even when HI is non-zero
        en   = 1'b0;
        mdOp = 4'd5;
        #2;
        chk("en0_mdout", mdOut, 32'd0);
        mdOp = 4'd9;
        en   = 1'b1;
        #2;
        chk("badop_mdout", mdOut, 32'd0);
        idle_inputs();
        step();

        issue(4'd7, 32'd5, 32'd0);
        issue(4'd8, 32'd6, 32'd0);
        run_op(4'd3, 32'd100, 32'd0, 10, "divzero");
        read(4'd5, 32'd5, "divzero_hi");
        read(4'd6, 32'd6, "divzero_lo");

        // mult 3*4, then a multu and an mtlo are presented while busy
        issue(4'd1, 32'd3, 32'd4);
        en = 1'b1; mdOp = 4'd2; srcA = 32'd7;  srcB = 32'd7;
        step();
        en = 1'b1; mdOp = 4'd8; srcA = 32'd99; srcB = 32'd0;
        step();
        idle_inputs();
        count_busy(c);
        chk("busy_ignore_cycles", 32'(c), 32'd3);
        read(4'd5, 32'd0, "busy_ignore_hi");
        read(4'd6, 32'd12, "busy_ignore_lo");

        run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 10, "div_ovf");
        read(4'd6, 32'h80000000, "div_ovf_lo");
        read(4'd5, 32'h00000000, "div_ovf_hi");

        // async reset in the third busy cycle of a div
        issue(4'd7, 32'd5, 32'd0);
        issue(4'd3, 32'd100, 32'd3);
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        step();
        reset = 1'b0;
        repeat (12) step();
        chk("midreset_busy_later", {31'd0, busy}, 32'd0);
        read(4'd5, 32'd0, "midreset_hi");
        read(4'd6, 32'd0, "midreset_lo");

        repeat (3) step();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
Multiply/divide unit in the E stage of the five-stage MIPS pipeline, next to the ALU. It consumes the mdOp code that the control decoder produces for mult/multu/div/divu/mfhi/mflo/mthi/mtlo. It owns the HI/LO registers and models multi-cycle latency with a busy flag, which the hazard unit uses to stall D-stage md-class instructions.

Parameters:
MULT_CYCLES, 5, busy duration in cycles for mult/multu
DIV_CYCLES, 10, busy duration in cycles for div/divu

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
en  input  1  E-stage instruction is valid (not a bubble)
mdOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; others treated as none
srcA  input  32  GPR[rs] (forwarded)
srcB  input  32  GPR[rt] (forwarded)
busy  output  1  operation in progress
mdOut  output  32  mfhi/mflo read data

Behaviour:
- Reset (async, any time, including mid-operation):
  - HI=0, LO=0, busy=0, counter=0.
  - Any pending result is discarded.
- States:
  - IDLE (busy=0) and RUN (busy=1).
  - An internal counter, 4 bits minimum, sized to hold max(MULT_CYCLES, DIV_CYCLES).
  - Pending-result registers pendHI/pendLO.
- Start condition: en=1, mdOp in {1..4}, busy=0.
  - At that edge, compute pendHI/pendLO from srcA/srcB.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Set busy=1.
- busy timing: if start is sampled at edge T0, busy=1 for exactly N cycles (T0..T0+N).
- Completion, at edge T0+N:
  - HI<=pendHI, LO<=pendLO, busy<=0.
  - New HI/LO are visible to mfhi in the cycle after busy falls.
- Arithmetic:
  - mult: signed 64-bit product; {HI,LO}=srcA*srcB.
  - multu: unsigned 64-bit product.
  - div: LO=quotient, truncated toward zero; HI=remainder, carrying the sign of the dividend.
    - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned quotient and remainder.
  - srcB=0 for div/divu: busy still runs DIV_CYCLES, but HI/LO keep their previous values at completion.
- mthi/mtlo (en=1, busy=0): HI<=srcA (resp. LO<=srcA) at the edge; no busy.
- mfhi/mflo: mdOut=HI (mdOp 5) or LO (mdOp 6), combinational from the current registers.
  - mdOut=0 for any other mdOp or when en=0.
  - mdOut is defined regardless of busy; the hazard unit is responsible for not issuing a read while busy.
- Any mdOp 1..4, 7 or 8 with busy=1: ignored (no state change).
  - The hazard unit stalls before this happens; the block stays safe regardless.
- en=0: no start and no write, whatever mdOp is.
- Simultaneous events: completion and a new start cannot occur at the same edge, because start requires busy=0. A start is therefore accepted at the earliest on the edge after busy falls.

Test Plan:
- mult, srcA=0xFFFFFFFF, srcB=2 → busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE; mflo gives mdOut=0xFFFFFFFE.
- multu, same operands → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div 0xFFFFFFF9 / 2 (-7/2) → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu 7/2 → LO=3, HI=1.
- mthi 0x12345678, then mtlo 0x0 → mfhi returns 0x12345678 the next cycle; busy stays 0.
- Edge cases:
  - div by zero after HI=5, LO=6 → busy 10 cycles; HI=5, LO=6 unchanged.
  - mult issued with busy=1 → ignored.
  - reset asserted at cycle 3 of a div → busy=0, HI=LO=0 immediately.
  - div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
